// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enable/clear data register among NREQ requesters.
// A global clear request takes priority over pending writes; all outputs are registered.
module reg_write_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic                  clr_req,
   output logic [NREQ-1:0]       ack,
   output logic                  clr_ack,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy,
   output logic                  reg_enable,
   output logic                  reg_clear,
   output logic [WIDTH-1:0]      reg_d
);

   typedef enum logic [1:0] {IDLE, GNT, ACK, CLR} state_t;

   state_t           state, state_n;
   logic [IDW-1:0]   ptr, ptr_n, gid_n, winner;
   logic [WIDTH-1:0] d_n;
   logic [NREQ-1:0]  ack_n;
   logic             clr_ack_n, en_n, clr_n;

   // Scan from the far end toward ptr+1 so the closest requester overwrites the rest.
   always_comb begin
      int idx;
      winner = '0;
      idx    = 0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx]) winner = idx[IDW-1:0];
      end
   end

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      gid_n     = grant_id;
      d_n       = reg_d;
      ack_n     = '0;
      clr_ack_n = 1'b0;
      en_n      = 1'b0;
      clr_n     = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_n   = CLR;
               clr_n     = 1'b1;
               clr_ack_n = 1'b1;
            end else if (|req) begin
               state_n = GNT;
               gid_n   = winner;
               d_n     = req_data[winner*WIDTH +: WIDTH];
               en_n    = 1'b1;
            end
         end
         GNT: begin
            state_n         = ACK;
            ack_n[grant_id] = 1'b1;
         end
         ACK: begin
            state_n = IDLE;
            ptr_n   = grant_id;
         end
         CLR:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ptr        <= IDW'(NREQ - 1);
         grant_id   <= '0;
         reg_d      <= '0;
         ack        <= '0;
         clr_ack    <= 1'b0;
         busy       <= 1'b0;
         reg_enable <= 1'b0;
         reg_clear  <= 1'b0;
      end else begin
         state      <= state_n;
         ptr        <= ptr_n;
         grant_id   <= gid_n;
         reg_d      <= d_n;
         ack        <= ack_n;
         clr_ack    <= clr_ack_n;
         busy       <= (state_n != IDLE);
         reg_enable <= en_n;
         reg_clear  <= clr_n;
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed table, hand-written corner sequences, and random
// traffic checked against a transaction-schedule model of the arbiter.
module tb_reg_write_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic           clr_req;
   logic [N-1:0]   ack;
   logic           clr_ack, busy, reg_enable, reg_clear;
   logic [1:0]     grant_id;
   logic [W-1:0]   reg_d;

   logic [2:0]  req3, ack3;
   logic [23:0] data3;
   logic        clr3, cack3, busy3, en3, clrr3;
   logic [1:0]  gid3;
   logic [7:0]  d3;

   always #5 clock = ~clock;

   reg_write_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clock(clock), .reset(reset), .req(req), .req_data(req_data), .clr_req(clr_req),
      .ack(ack), .clr_ack(clr_ack), .grant_id(grant_id), .busy(busy),
      .reg_enable(reg_enable), .reg_clear(reg_clear), .reg_d(reg_d));

   reg_write_arbiter #(.WIDTH(8), .NREQ(3)) dut3 (
      .clock(clock), .reset(reset), .req(req3), .req_data(data3), .clr_req(clr3),
      .ack(ack3), .clr_ack(cack3), .grant_id(gid3), .busy(busy3),
      .reg_enable(en3), .reg_clear(clrr3), .reg_d(d3));

   typedef struct packed {
      logic       en;
      logic       clr;
      logic [3:0] ack;
      logic       cack;
      logic       busy;
      logic [1:0] gid;
      logic [7:0] d;
   } obs_t;

   typedef struct {
      logic [3:0]  req;
      logic        clr;
      logic [31:0] data;
      obs_t        exp;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;

   // Model: upcoming per-cycle outputs for a transaction in flight; empty means the arbiter listens.
   obs_t       sched[$];
   int         m_ptr;
   logic [1:0] m_gid;
   logic [7:0] m_d;
   int         cyc = 0;

   function automatic obs_t mk(logic en, logic clr, logic [3:0] a, logic ca, logic b,
                               logic [1:0] g, logic [7:0] d);
      obs_t o;
      o.en = en; o.clr = clr; o.ack = a; o.cack = ca; o.busy = b; o.gid = g; o.d = d;
      return o;
   endfunction

   function automatic obs_t idle_obs();
      return mk(1'b0, 1'b0, 4'b0, 1'b0, 1'b0, m_gid, m_d);
   endfunction

   function automatic obs_t dut_obs();
      return mk(reg_enable, reg_clear, ack, clr_ack, busy, grant_id, reg_d);
   endfunction

   task automatic cmp_obs(string nm, obs_t e);
      obs_t g;
      g = dut_obs();
      vectors++;
      if (g !== e) begin
         miscompares++;
         $display("FAIL %s: got en=%b clr=%b ack=%b cack=%b busy=%b gid=%0d d=%h, want en=%b clr=%b ack=%b cack=%b busy=%b gid=%0d d=%h",
                  nm, g.en, g.clr, g.ack, g.cack, g.busy, g.gid, g.d,
                  e.en, e.clr, e.ack, e.cack, e.busy, e.gid, e.d);
      end
   endtask

   task automatic chk(string nm, int got, int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      sched.delete();
      m_ptr = N - 1;
      m_gid = 2'd0;
      m_d   = 8'h00;
   endtask

   // One clock: model decides what the next cycle looks like, DUT is compared on the falling edge.
   task automatic step(string nm);
      obs_t e, a;
      int   w;
      @(posedge clock);
      cyc++;
      if (sched.size() > 0) begin
         e = sched.pop_front();
      end else if (clr_req) begin
         e = idle_obs();
         e.clr = 1'b1; e.cack = 1'b1; e.busy = 1'b1;
         sched.push_back(idle_obs());
      end else if (req != 0) begin
         w = -1;
         for (int k = 1; k <= N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         m_gid = w[1:0];
         m_d   = req_data[w*W +: W];
         m_ptr = w;
         e = idle_obs();
         e.en = 1'b1; e.busy = 1'b1;
         a = idle_obs();
         a.ack = 4'b1 << w; a.busy = 1'b1;
         sched.push_back(a);
         sched.push_back(idle_obs());
      end else begin
         e = idle_obs();
      end
      @(negedge clock);
      cmp_obs(nm, e);
      chk({nm, "_inv"}, int'((reg_enable && reg_clear) || ((ack & (ack - 4'd1)) != 0) ||
                             ((ack != 0) && clr_ack) || (en3 && clrr3)), 0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0; req = '0; clr_req = 1'b0; req3 = '0;
      #1;
      model_reset();
      cmp_obs("reset", idle_obs());
      @(negedge clock);
      reset = 1'b1;
   endtask

   vec_t tbl[9];

   initial begin
      int g[$];
      int dv[$];
      int tc[$];

      req = '0; req_data = '0; clr_req = 1'b0;
      req3 = '0; data3 = 24'h332211; clr3 = 1'b0;

      tbl[0] = '{4'b0100, 1'b0, 32'h005A0000, mk(1, 0, 4'b0000, 0, 1, 2'd2, 8'h5A)};
      tbl[1] = '{4'b0100, 1'b0, 32'h00A50000, mk(0, 0, 4'b0100, 0, 1, 2'd2, 8'h5A)};
      tbl[2] = '{4'b0000, 1'b0, 32'h00A50000, mk(0, 0, 4'b0000, 0, 0, 2'd2, 8'h5A)};
      tbl[3] = '{4'b0000, 1'b0, 32'h00A50000, mk(0, 0, 4'b0000, 0, 0, 2'd2, 8'h5A)};
      tbl[4] = '{4'b0010, 1'b1, 32'h00007700, mk(0, 1, 4'b0000, 1, 1, 2'd2, 8'h5A)};
      tbl[5] = '{4'b0010, 1'b0, 32'h00007700, mk(0, 0, 4'b0000, 0, 0, 2'd2, 8'h5A)};
      tbl[6] = '{4'b0010, 1'b0, 32'h00007700, mk(1, 0, 4'b0000, 0, 1, 2'd1, 8'h77)};
      tbl[7] = '{4'b0010, 1'b0, 32'h00007700, mk(0, 0, 4'b0010, 0, 1, 2'd1, 8'h77)};
      tbl[8] = '{4'b0000, 1'b0, 32'h00007700, mk(0, 0, 4'b0000, 0, 0, 2'd1, 8'h77)};

      // Single write, then clear racing a write in the same idle cycle.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         req = tbl[i].req; clr_req = tbl[i].clr; req_data = tbl[i].data;
         step("tbl_model");
         cmp_obs($sformatf("tbl%0d", i), tbl[i].exp);
      end

      // All four request at once: cyclic order, acks three cycles apart.
      do_reset();
      req = 4'b1111; req_data = 32'h13121110;
      for (int i = 0; i < 30 && g.size() < 4; i++) begin
         step("t2");
         if (ack != 0) begin
            g.push_back(int'(grant_id)); dv.push_back(int'(reg_d)); tc.push_back(cyc);
            req = req & ~ack;
         end
      end
      chk("t2_count", g.size(), 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t2_gid%0d", k), (k < g.size()) ? g[k] : -1, k);
         chk($sformatf("t2_d%0d", k), (k < dv.size()) ? dv[k] : -1, 16 + k);
         if (k > 0) chk($sformatf("t2_gap%0d", k), (k < tc.size()) ? tc[k] - tc[k-1] : -1, 3);
      end

      // req[0] and req[3] held: strict alternation.
      do_reset();
      g.delete();
      req = 4'b1001; req_data = 32'hD0000000 | 32'h000000B0;
      for (int i = 0; i < 40 && g.size() < 4; i++) begin
         step("t3");
         if (ack != 0) g.push_back(int'(grant_id));
         req = 4'b1001 & ~ack;
      end
      req = '0;
      chk("t3_count", g.size(), 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("t3_gid%0d", k), (k < g.size()) ? g[k] : -1, (k % 2 == 0) ? 0 : 3);

      // Clear arriving during GNT is deferred until the write completes.
      do_reset();
      req = 4'b0100; req_data = 32'h00A50000;
      step("t5");
      clr_req = 1'b1;
      step("t5");
      chk("t5_ack", int'(ack), 4);
      chk("t5_noclr1", int'(reg_clear), 0);
      req = '0;
      step("t5");
      chk("t5_noclr2", int'(reg_clear), 0);
      step("t5");
      chk("t5_clr", int'(reg_clear), 1);
      chk("t5_clrack", int'(clr_ack), 1);
      clr_req = 1'b0;
      step("t5");

      // Reset mid-GNT with req[3] held: no ack, requester 3 granted afresh afterwards.
      do_reset();
      req = 4'b1000; req_data = 32'hC3000000;
      step("t6");
      #1;
      reset = 1'b0;
      #1;
      model_reset();
      cmp_obs("t6_async", idle_obs());
      @(posedge clock);
      @(negedge clock);
      cmp_obs("t6_hold", idle_obs());
      reset = 1'b1;
      step("t6");
      chk("t6_gid", int'(grant_id), 3);
      chk("t6_en", int'(reg_enable), 1);
      step("t6");
      chk("t6_ack", int'(ack), 8);
      req = '0;
      step("t6");

      // Three-requester build wraps 2 -> 0 and never names index 3.
      do_reset();
      g.delete();
      req3 = 3'b111;
      for (int i = 0; i < 30 && g.size() < 4; i++) begin
         step("t7");
         chk("t7_range", int'(gid3 < 2'd3), 1);
         if (ack3 != 0) g.push_back(int'(gid3));
         req3 = 3'b111 & ~ack3;
      end
      req3 = '0;
      chk("t7_count", g.size(), 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("t7_gid%0d", k), (k < g.size()) ? g[k] : -1, k % 3);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         logic [3:0] just_acked;
         step("rand");
         just_acked = ack;
         req = req & ~ack;
         if (clr_ack) clr_req = 1'b0;
         else if (!clr_req && $urandom_range(19) == 0) clr_req = 1'b1;
         for (int r = 0; r < N; r++) begin
            if (!req[r] && !just_acked[r] && $urandom_range(2) == 0) begin
               req[r] = 1'b1;
               req_data[r*W +: W] = 8'($urandom);
            end else if ($urandom_range(7) == 0) begin
               req_data[r*W +: W] = 8'($urandom);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
